// File: rtl/alu_pkg.sv
// Shared types for the ALU result path: NZCV flag layout, the registered
// result record and the occupancy encoding of the output stage.
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int ALU_TAG_W = 4;

  // Bit positions of each flag in the external 4-bit {N,Z,C,V} vector.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] result;
    alu_flags_t           flags;
    logic [ALU_TAG_W-1:0] tag;
  } alu_result_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_t;

  function automatic logic [3:0] flags_to_bits(input alu_flags_t f);
    logic [3:0] bits;
    bits         = '0;
    bits[FLAG_N] = f.n;
    bits[FLAG_Z] = f.z;
    bits[FLAG_C] = f.c;
    bits[FLAG_V] = f.v;
    return bits;
  endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational NZCV derivation from the raw adder outputs. Carry is passed
// through unchanged, so for subtract C=1 means "no borrow".
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] sum,
  input  logic             carry,
  input  logic             overflow,
  output alu_flags_t       flags
);

  always_comb begin
    flags   = '0;
    flags.n = sum[WIDTH-1];
    flags.z = (sum == '0);
    flags.c = carry;
    flags.v = overflow;
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered result/flag stage behind the ALU adder: main register plus one
// skid register, registered in_ready, and a sticky overflow status bit.
module alu_result_stage
  import alu_pkg::*;
#(
  // Storage uses the package record, so these must match ALU_WIDTH/ALU_TAG_W.
  parameter int WIDTH = ALU_WIDTH,
  parameter int TAG_W = ALU_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_carry,
  input  logic             in_overflow,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic [TAG_W-1:0] out_tag,
  input  logic             sticky_clr,
  output logic             sticky_v
);

  occ_state_t  state_q;
  occ_state_t  state_d;
  alu_flags_t  in_flags;
  alu_result_t in_item;
  alu_result_t main_q;
  alu_result_t skid_q;
  logic        in_ready_q;
  logic        sticky_q;
  logic        accept;
  logic        xfer;
  logic        main_from_in;
  logic        main_from_skid;
  logic        skid_load;

  alu_flag_gen #(
    .WIDTH (WIDTH)
  ) u_flag_gen (
    .sum      (in_sum),
    .carry    (in_carry),
    .overflow (in_overflow),
    .flags    (in_flags)
  );

  assign in_item = '{result: in_sum, flags: in_flags, tag: in_tag};

  assign out_valid = (state_q != OCC_EMPTY);
  assign accept    = in_valid && in_ready_q;
  assign xfer      = out_valid && out_ready;

  // Next occupancy and register load enables.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_d        = state_q;
    main_from_in   = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    case (state_q)
      OCC_EMPTY: begin
        if (accept) begin
          main_from_in = 1'b1;
          state_d      = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (accept && xfer) begin
          main_from_in = 1'b1;
        end else if (accept) begin
          skid_load = 1'b1;
          state_d   = OCC_FULL;
        end else if (xfer) begin
          state_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        // in_ready is low here, so nothing can be accepted.
        if (xfer) begin
          main_from_skid = 1'b1;
          state_d        = OCC_ONE;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= OCC_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      // NOTE: state elements use non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q    <= state_d;
      in_ready_q <= (state_d != OCC_FULL);
    end
  end

  // NOTE: the data registers are reset as well, because the presented
  // result, flags and tag are defined to read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (main_from_in) begin
        main_q <= in_item;
      end else if (main_from_skid) begin
        main_q <= skid_q;
      end
      if (skid_load) begin
        skid_q <= in_item;
      end
    end
  end

  // Sticky V follows accepts, so a clear coinciding with an accepted
  // overflow still leaves the bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= (sticky_clr ? 1'b0 : sticky_q) | (accept && in_overflow);
    end
  end

  assign in_ready   = in_ready_q;
  assign out_result = main_q.result;
  assign out_flags  = flags_to_bits(main_q.flags);
  assign out_tag    = main_q.tag;
  assign sticky_v   = sticky_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus random
// traffic compared against a queue-based reference of the stage.
module tb_alu_result_stage;

  localparam int WIDTH = 32;
  localparam int TAG_W = 4;

  typedef struct packed {
    logic [WIDTH-1:0] r;
    logic [3:0]       f;
    logic [TAG_W-1:0] t;
  } item_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum;
  logic             in_carry;
  logic             in_overflow;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [3:0]       out_flags;
  logic [TAG_W-1:0] out_tag;
  logic             sticky_clr;
  logic             sticky_v;

  int    n_checks;
  int    n_errors;
  item_t model_q[$];
  logic  model_sticky;

  alu_result_stage #(
    .WIDTH (WIDTH),
    .TAG_W (TAG_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sum      (in_sum),
    .in_carry    (in_carry),
    .in_overflow (in_overflow),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_flags   (out_flags),
    .out_tag     (out_tag),
    .sticky_clr  (sticky_clr),
    .sticky_v    (sticky_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_flags(input logic [WIDTH-1:0] s, input logic c, input logic v);
    return {s[WIDTH-1], (s == 0), c, v};
  endfunction

  // Compare everything visible against the reference; data only when valid.
  task automatic compare_outputs();
    check("out_valid", 64'(out_valid), 64'(model_q.size() > 0));
    check("in_ready", 64'(in_ready), 64'(model_q.size() < 2));
    check("sticky_v", 64'(sticky_v), 64'(model_sticky));
    if (model_q.size() > 0) begin
      check("out_result", 64'(out_result), 64'(model_q[0].r));
      check("out_flags", 64'(out_flags), 64'(model_q[0].f));
      check("out_tag", 64'(out_tag), 64'(model_q[0].t));
    end
  endtask

  // One clock cycle: called and returns at a falling edge.
  task automatic step(input logic v, input logic [WIDTH-1:0] s, input logic c,
                      input logic o, input logic [TAG_W-1:0] t,
                      input logic ordy, input logic clr);
    logic acc;
    logic xf;
    compare_outputs();
    in_valid    = v;
    in_sum      = s;
    in_carry    = c;
    in_overflow = o;
    in_tag      = t;
    out_ready   = ordy;
    sticky_clr  = clr;
    @(posedge clk);
    acc = v && (model_q.size() < 2);
    xf  = (model_q.size() > 0) && ordy;
    if (xf) void'(model_q.pop_front());
    if (acc) model_q.push_back('{r: s, f: ref_flags(s, c, o), t: t});
    model_sticky = (clr ? 1'b0 : model_sticky) | (acc && o);
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1, 4'hF, ordy, 1'b0);
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    model_sticky = 1'b0;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_sum       = '0;
    in_carry     = 1'b0;
    in_overflow  = 1'b0;
    in_tag       = '0;
    out_ready    = 1'b0;
    sticky_clr   = 1'b0;

    // Reset state
    #12;
    compare_outputs();
    check("rst_result", 64'(out_result), 64'h0);
    check("rst_flags", 64'(out_flags), 64'h0);
    check("rst_tag", 64'(out_tag), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Add overflow: 0x7FFFFFFF + 1
    step(1'b1, 32'h8000_0000, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0);
    check("ovf_result", 64'(out_result), 64'h8000_0000);
    check("ovf_flags", 64'(out_flags), 64'b1001);
    check("ovf_tag", 64'(out_tag), 64'd3);
    check("ovf_sticky", 64'(sticky_v), 64'd1);

    // Subtract equal (5-5), then 3-4
    step(1'b1, 32'h0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0);
    check("sub_eq_flags", 64'(out_flags), 64'b0110);
    step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'd6, 1'b1, 1'b0);
    check("sub_lt_flags", 64'(out_flags), 64'b1000);
    idle(1'b1);

    // Backpressure fills main and skid
    step(1'b1, 32'h11, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0);
    step(1'b1, 32'h22, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    check("bp_hold_tag", 64'(out_tag), 64'd1);
    step(1'b1, 32'h33, 1'b0, 1'b0, 4'd7, 1'b0, 1'b0);
    check("bp_still_tag", 64'(out_tag), 64'd1);
    check("bp_still_result", 64'(out_result), 64'h11);
    idle(1'b1);
    check("bp_second_tag", 64'(out_tag), 64'd2);
    check("bp_in_ready_back", 64'(in_ready), 64'd1);
    idle(1'b1);
    check("bp_drained", 64'(out_valid), 64'd0);

    // Streaming: one per cycle, 1-cycle latency
    for (int i = 0; i < 8; i++) begin
      step(1'b1, $urandom, 1'(i & 1), 1'b0, 4'(i), 1'b1, 1'b0);
      check("stream_tag", 64'(out_tag), 64'(i));
      check("stream_in_ready", 64'(in_ready), 64'd1);
    end
    idle(1'b1);

    // Sticky clear racing an accepted overflow
    step(1'b1, 32'h7, 1'b0, 1'b1, 4'd8, 1'b1, 1'b1);
    check("sticky_set_wins", 64'(sticky_v), 64'd1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    check("sticky_cleared", 64'(sticky_v), 64'd0);
    idle(1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [WIDTH-1:0] s;
      case ($urandom_range(0, 7))
        0:       s = 32'h0;
        1:       s = 32'hFFFF_FFFF;
        2:       s = 32'h8000_0000;
        default: s = $urandom;
      endcase
      step(($urandom_range(0, 3) != 0), s, 1'($urandom), 1'($urandom_range(0, 5) == 0),
           4'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0));
    end

    // Reset mid-operation from FULL with sticky set
    idle(1'b1);
    idle(1'b1);
    step(1'b1, 32'hAAAA_0001, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0);
    step(1'b1, 32'hAAAA_0002, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0);
    compare_outputs();
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_sticky", 64'(sticky_v), 64'd0);
    check("mid_rst_result", 64'(out_result), 64'h0);
    model_q.delete();
    model_sticky = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'h1234, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0);
    check("post_rst_tag", 64'(out_tag), 64'd9);
    check("post_rst_result", 64'(out_result), 64'h1234);
    idle(1'b0);
    check("post_rst_alone_ready", 64'(in_ready), 64'd1);
    idle(1'b1);
    check("post_rst_empty", 64'(out_valid), 64'd0);
    compare_outputs();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
Registered output stage directly downstream of the 32-bit ALU adder. It captures the adder's sum, carry_out and overflow, derives the NZCV condition flags and presents them to the writeback consumer. Transfers use a valid/ready handshake with a 2-entry skid buffer, so full throughput is kept without a combinational ready path. It also maintains a sticky overflow bit for exception and status logic.

Parameters:
WIDTH, 32, datapath width of sum and result.
TAG_W, 4, width of the opaque destination/op tag carried alongside each result.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  upstream has a valid adder result.
in_ready  output  1  stage can accept; registered, no combinational path from out_ready.
in_sum  input  WIDTH  adder sum.
in_carry  input  1  adder carry_out.
in_overflow  input  1  adder signed overflow.
in_tag  input  TAG_W  tag, passed through unmodified.
out_valid  output  1  result/flags valid.
out_ready  input  1  downstream accepts.
out_result  output  WIDTH  registered sum.
out_flags  output  4  {N,Z,C,V}.
out_tag  output  TAG_W  tag of the presented result.
sticky_clr  input  1  synchronous clear of sticky_v.
sticky_v  output  1  set if any accepted result had V=1 since the last clear.

Behaviour:
- Reset (async on rst_n low): out_valid=0, in_ready=1, skid empty, sticky_v=0. out_result, out_flags and out_tag = 0.
- Flag rules, computed from the accepted input:
  - N = in_sum[WIDTH-1].
  - Z = (in_sum == 0).
  - C = in_carry, passed raw. For subtract, C=1 means no borrow.
  - V = in_overflow.
- Input handshake: accept when in_valid && in_ready. Output handshake: transfer when out_valid && out_ready.
- Latency: 1 cycle. An item accepted in cycle t is on out_* in cycle t+1 when the main register is free.
- Storage is a main register plus one skid register. Occupancy states are EMPTY, ONE and FULL (main + skid).
  - EMPTY: accept goes to main -> ONE.
  - ONE: accept with out transfer -> main reloads, stay ONE. Accept without transfer -> skid loads -> FULL. Transfer without accept -> EMPTY.
  - FULL: in_ready=0, so no accept. Transfer -> skid moves to main -> ONE.
- in_ready = (state != FULL), driven from a register. Throughput is 1 item/cycle while out_ready stays high.
- Data ordering is strictly FIFO. No item is dropped or duplicated.
- in_sum, in_carry, in_overflow and in_tag are ignored while in_valid=0. Outputs hold stable while out_valid && !out_ready.
- Sticky overflow:
  - next sticky_v = (sticky_clr ? 0 : sticky_v) | (accept && in_overflow).
  - An overflow accepted in the same cycle as sticky_clr leaves sticky_v=1.
  - sticky_v updates on accept, not on output transfer.
- Reset mid-operation discards all buffered items immediately. The next cycle after release behaves as EMPTY.

Decomposition:
- Package alu_pkg holds:
  - localparams FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - typedef alu_flags_t as packed struct {n,z,c,v}.
  - typedef alu_result_t as packed struct {result, flags, tag}. It is used for both the main and skid registers.
- Sub-module alu_flag_gen: combinational, sum/carry/overflow -> alu_flags_t. It is instantiated once on the input side so flags are registered with the data.

Test Plan:
- Add overflow: in_sum=0x80000000, carry=0, ovf=1, tag=3 (0x7FFFFFFF+1) -> next cycle out_result=0x80000000, out_flags=4'b1001, out_tag=3, sticky_v=1.
- Subtract equal: in_sum=0, carry=1, ovf=0 (5-5) -> out_flags=4'b0110. Then in_sum=0xFFFFFFFF, carry=0 (3-4) -> out_flags=4'b1000.
- Backpressure: out_ready=0, push tags 1,2 on consecutive cycles -> in_ready=0 the cycle after the second accept, out_tag holds 1. Raise out_ready -> tags 1,2 emerge on consecutive cycles, in_ready returns to 1.
- Streaming: out_ready=1, in_valid=1 for 8 cycles with tags 0..7 -> tags 0..7 out in order, one per cycle, 1-cycle latency, in_ready never deasserts.
- Sticky: sticky_clr=1 in the same cycle as an accepted ovf=1 -> sticky_v=1. Next cycle sticky_clr=1 with no overflow -> sticky_v=0.
- Reset mid-operation: FULL state (2 items held), pulse rst_n low asynchronously -> out_valid=0, in_ready=1, sticky_v=0 immediately. After release, a single push appears alone after 1 cycle.
